// File: rtl/m65c02_bus_pkg.sv
// Shared types for the M65C02 bus controller: bus op encodings, region and FSM state enums.
package m65c02_bus_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_IF   = 2'b11
    } io_op_e;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_IO
    } region_e;

    typedef enum logic [1:0] {
        StIdle,
        StCoreWs,
        StDmaWs
    } state_e;

    // Counter width able to hold the largest wait-state value (at least one bit).
    function automatic int unsigned ws_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m == 0) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/m65c02_bus_dec.sv
// Address decoder: maps a bus address to a one-hot region enable and its wait-state count.
module m65c02_bus_dec
    import m65c02_bus_pkg::*;
#(
    parameter int unsigned pWS_RAM  = 0,
    parameter int unsigned pWS_ROM  = 2,
    parameter int unsigned pWS_IO   = 3,
    parameter logic [7:0]  pIO_Page = 8'hFE,
    parameter int unsigned CntW     = 2
) (
    input  logic [15:0]     addr,
    output logic [2:0]      ce,
    output logic [CntW-1:0] ws
);

    region_e region;

    always_comb begin
        if (addr[15:8] == pIO_Page) begin
            region = RGN_IO;
        end else if (addr[15]) begin
            region = RGN_ROM;
        end else begin
            region = RGN_RAM;
        end
    end

    // ce bit order: [2]=RAM, [1]=ROM, [0]=IO
    always_comb begin
        ce = 3'b000;
        ws = '0;
        case (region)
            RGN_RAM: begin ce = 3'b100; ws = CntW'(pWS_RAM); end
            RGN_ROM: begin ce = 3'b010; ws = CntW'(pWS_ROM); end
            RGN_IO:  begin ce = 3'b001; ws = CntW'(pWS_IO);  end
            default: begin ce = 3'b000; ws = '0;             end
        endcase
    end

endmodule

// File: rtl/m65c02_bus_arb.sv
// Bus controller between the M65C02 core and board memory: region decode, wait-state
// insertion and core-priority sharing with one DMA requester under a starvation limit.
module m65c02_bus_arb
    import m65c02_bus_pkg::*;
#(
    parameter int unsigned pWS_RAM  = 0,
    parameter int unsigned pWS_ROM  = 2,
    parameter int unsigned pWS_IO   = 3,
    parameter logic [7:0]  pIO_Page = 8'hFE,
    parameter int unsigned pMaxCore = 4
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic [1:0]  IO_Op,
    input  logic [15:0] AO,
    input  logic [7:0]  DO,
    output logic [7:0]  DI,
    output logic        Wait,
    input  logic        DMA_Req,
    input  logic        DMA_Wr,
    input  logic [15:0] DMA_AO,
    input  logic [7:0]  DMA_DO,
    output logic        DMA_Ack,
    output logic [7:0]  DMA_DI,
    output logic [15:0] MemAO,
    output logic [1:0]  MemOp,
    output logic [7:0]  MemDO,
    input  logic [7:0]  MemDI,
    output logic        CE_RAM,
    output logic        CE_ROM,
    output logic        CE_IO,
    output logic        Owner
);

    localparam int unsigned CntW    = ws_width(pWS_RAM, pWS_ROM, pWS_IO);
    localparam int unsigned StarveW = $clog2(pMaxCore + 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StarveW-1:0]  starve_q, starve_d, starve_inc;
    logic                owner_q, owner_d;
    logic                ack_q, ack_d;
    logic [7:0]          dma_di_q, dma_di_d;
    logic [2:0]          core_ce_q, core_ce_d;

    logic [2:0]          core_ce, dma_ce, ce;
    logic [CntW-1:0]     core_ws, dma_ws;
    logic                core_op, dma_req, starve_max, grant_core;

    m65c02_bus_dec #(
        .pWS_RAM (pWS_RAM),
        .pWS_ROM (pWS_ROM),
        .pWS_IO  (pWS_IO),
        .pIO_Page(pIO_Page),
        .CntW    (CntW)
    ) u_core_dec (
        .addr(AO),
        .ce  (core_ce),
        .ws  (core_ws)
    );

    m65c02_bus_dec #(
        .pWS_RAM (pWS_RAM),
        .pWS_ROM (pWS_ROM),
        .pWS_IO  (pWS_IO),
        .pIO_Page(pIO_Page),
        .CntW    (CntW)
    ) u_dma_dec (
        .addr(DMA_AO),
        .ce  (dma_ce),
        .ws  (dma_ws)
    );

    // The acknowledged request is still high in the Ack cycle; ignore it so it is not re-granted.
    assign core_op    = (IO_Op != OP_NONE);
    assign dma_req    = DMA_Req && !ack_q;
    assign starve_max = (starve_q == StarveW'(pMaxCore));
    assign starve_inc = starve_max ? starve_q : starve_q + StarveW'(1);
    assign grant_core = (state_q == StIdle) && core_op && !(dma_req && starve_max);

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            starve_q  <= '0;
            owner_q   <= 1'b0;
            ack_q     <= 1'b0;
            dma_di_q  <= 8'h00;
            core_ce_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            owner_q   <= owner_d;
            ack_q     <= ack_d;
            dma_di_q  <= dma_di_d;
            core_ce_q <= core_ce_d;
        end
    end

    // Counter is loaded with WS-1 for the core since the grant clock already counts as one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        starve_d  = starve_q;
        owner_d   = owner_q;
        ack_d     = 1'b0;
        dma_di_d  = dma_di_q;
        core_ce_d = core_ce_q;
        case (state_q)
            StIdle: begin
                if (!dma_req) starve_d = '0;
                if (grant_core) begin
                    if (core_ws == '0) begin
                        if (dma_req) starve_d = starve_inc;
                    end else begin
                        state_d   = StCoreWs;
                        cnt_d     = core_ws - CntW'(1);
                        core_ce_d = core_ce;
                    end
                end else if (dma_req) begin
                    state_d = StDmaWs;
                    cnt_d   = dma_ws;
                    owner_d = 1'b1;
                end
            end
            StCoreWs: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (DMA_Req) starve_d = starve_inc;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDmaWs: begin
                if (cnt_q == '0) begin
                    ack_d    = 1'b1;
                    if (!DMA_Wr) dma_di_d = MemDI;
                    starve_d = '0;
                    owner_d  = 1'b0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        MemAO = AO;
        MemDO = DO;
        MemOp = OP_NONE;
        ce    = 3'b000;
        Wait  = 1'b0;
        if (owner_q) begin
            MemAO = DMA_AO;
            MemDO = DMA_DO;
            MemOp = DMA_Wr ? OP_WR : OP_RD;
            ce    = dma_ce;
        end else if (state_q == StCoreWs) begin
            MemOp = IO_Op;
            ce    = core_ce_q;
        end else if (grant_core) begin
            MemOp = IO_Op;
            ce    = core_ce;
        end
        case (state_q)
            StIdle:   Wait = core_op && (!grant_core || (core_ws != '0));
            StCoreWs: Wait = (cnt_q != '0);
            StDmaWs:  Wait = core_op;
            default:  Wait = 1'b0;
        endcase
        if (!nRst) begin
            MemOp = OP_NONE;
            ce    = 3'b000;
            Wait  = 1'b0;
        end
    end

    assign {CE_RAM, CE_ROM, CE_IO} = ce;
    assign DI      = MemDI;
    assign DMA_Ack = ack_q;
    assign DMA_DI  = dma_di_q;
    assign Owner   = owner_q;

endmodule
